burst_stats_accum: RTL and testbench
====================================

Name: burst_stats_accum

Overview:
- Post-processing stage on sys_clk, directly downstream of the square-root pipeline.
- Consumes the non-stallable stream of sqrt results, each tagged with its burst-last flag.
- Per burst, accumulates sum, sample count, min and max, then pushes one result record into a small internal result FIFO.
- The clock-crossing output FIFO drains that FIFO through a valid/ready handshake; bursts that cannot be stored are dropped and counted.

Parameters:
DWID, 20, width of input sample (sqrt result)
SWID, 32, width of burst sum (saturating)
CWID, 16, width of sample count (saturating)
DEPTH, 4, result FIFO depth in records (power of 2, >=2)

Ports:
sys_clk  in  1  clock
rst_n  in  1  async active-low reset
vldin  in  1  sample valid; no backpressure, every valid beat must be consumed
din  in  DWID  unsigned sample
lastin  in  1  sample is last of burst (qualified by vldin)
softreset  in  1  synchronous clear of burst state, FIFO and drop_count
out_valid  out  1  result record available
out_ready  in  1  consumer accepts record
out_sum  out  SWID  burst sum
out_count  out  CWID  burst sample count
out_min  out  DWID  burst minimum
out_max  out  DWID  burst maximum
out_flags  out  2  [0] sum saturated, [1] count saturated
busy  out  1  burst in progress (state ACCUM)
drop_count  out  16  results dropped due to full FIFO, saturating

Behaviour:
- Reset (rst_n low, async): state IDLE; accumulators 0; FIFO empty; out_valid=0; out_sum/out_count/out_min/out_max/out_flags=0; busy=0; drop_count=0.
- FSM states: IDLE and ACCUM.
  - IDLE + vldin & !lastin: load sum=din, count=1, min=max=din, flags=0; go to ACCUM.
  - IDLE + vldin & lastin: single-beat burst; push record {din,1,din,din,0}; stay IDLE.
  - ACCUM + vldin: update sum, count, min, max and flags.
  - ACCUM + vldin & lastin: push the record built from the updated values (this beat included); go to IDLE.
  - No vldin: hold state.
- Arithmetic:
  - din is zero-extended to SWID.
  - If sum+din exceeds 2^SWID-1, sum = all ones and flags[0] is set (sticky for the burst).
  - count saturates at 2^CWID-1; flags[1] is set when an increment is blocked.
  - min/max use unsigned compare; on ties the held value is kept.
- Push timing: the record is written into the FIFO at the same edge that samples the last beat. out_valid rises in the following cycle when the FIFO was empty (latency 1 cycle).
- Output:
  - out_* present the FIFO head combinationally from registered storage.
  - Pop on out_valid & out_ready.
  - Records leave in arrival order.
  - out_* hold stable while out_valid & !out_ready.
- Full FIFO:
  - Push with FIFO full and no pop in the same cycle: record discarded; drop_count+1 (saturates at 0xFFFF); FSM still returns to IDLE.
  - Full FIFO with pop and push in the same cycle: push accepted, no drop.
- Empty FIFO: out_ready is ignored; no pointer movement.
- Pointers: log2(DEPTH)+1 bits, wrap naturally; full and empty derived from the MSB difference.
- softreset:
  - Forces IDLE, clears accumulators, FIFO and drop_count at the next edge.
  - A sample arriving in the same cycle is ignored (the partial burst is lost).
  - out_valid=0 the following cycle.
- rst_n asserted mid-burst or mid-drain: immediate clear; no partial record is ever emitted.
- busy = (state==ACCUM).

Decomposition:
- Shared package burst_stats_pkg:
  - default widths DWID/SWID/CWID;
  - flag bit indices FLAG_SAT=0, FLAG_CNT=1;
  - packed record typedef stats_rec_t {sum, count, min, max, flags} and its width constant.
- One sub-module burst_stats_fifo:
  - parameterised by record width and DEPTH;
  - push/pop/full/empty/softreset, simultaneous push+pop when full;
  - instantiated once.
- Top level holds the FSM, the accumulators and drop logic.

Test Plan:
- Burst din=3,5,1,7 with lastin on 7, out_ready=1 -> exactly one record: sum=16, count=4, min=1, max=7, flags=0; out_valid high the cycle after the last beat, for 1 cycle.
- Single-beat burst din=9, vldin&lastin in IDLE -> sum=9, count=1, min=max=9, busy never asserted.
- SWID=24 override, 17 beats of 0xFFFFF, last on 17th -> out_sum=0xFFFFFF, flags=2'b01, count=17.
- out_ready=0, five 2-beat bursts with DEPTH=4 -> out_valid=1, four records held, drop_count=1; then out_ready=1 drains the records in burst order 1..4.
- FIFO full, out_ready=1 in the same cycle as a last beat -> new record accepted, drop_count unchanged, all records retained.
- softreset after 2 beats of a burst, then burst din=2,2 (last) -> sum=4, count=2, no record from the aborted burst.

Source files
------------

// File: rtl/burst_stats_pkg.sv
// burst_stats_pkg: shared widths, flag indices, FSM states and result record layout
package burst_stats_pkg;
  localparam int DWID = 20;
  localparam int SWID = 32;
  localparam int CWID = 16;
  localparam int FLAG_SAT = 0;
  localparam int FLAG_CNT = 1;
  typedef enum logic {IDLE, ACCUM} state_t;
  typedef struct packed {
    logic [SWID-1:0] sum;
    logic [CWID-1:0] count;
    logic [DWID-1:0] min;
    logic [DWID-1:0] max;
    logic [1:0]      flags;
  } stats_rec_t;
  localparam int REC_W = $bits(stats_rec_t);
endpackage

// File: rtl/burst_stats_fifo.sv
// burst_stats_fifo: small record FIFO; a push into a full FIFO succeeds when a pop happens the same cycle
module burst_stats_fifo #(
  parameter int W     = 90,
  parameter int DEPTH = 4
) (
  input  logic         sys_clk,
  input  logic         rst_n,
  input  logic         softreset,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wp, r_rp;
  logic         w_pop, w_push;
  assign empty  = r_wp == r_rp;
  assign full   = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_pop  = pop & ~empty;
  assign w_push = push & (~full | w_pop);
  // head reads as zero when empty so the outputs stay clean after reset
  assign rdata  = empty ? '0 : r_mem[r_rp[AW-1:0]];
  always_ff @(posedge sys_clk or negedge rst_n)
    if (!rst_n) begin
      r_wp <= '0;
      r_rp <= '0;
    end else if (softreset) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      r_wp <= r_wp + {{AW{1'b0}}, w_push};
      r_rp <= r_rp + {{AW{1'b0}}, w_pop};
    end
  always_ff @(posedge sys_clk)
    if (w_push && !softreset) r_mem[r_wp[AW-1:0]] <= wdata;
endmodule

// File: rtl/burst_stats_accum.sv
// burst_stats_accum: per-burst sum/count/min/max of a non-stallable sample stream, buffered in a result FIFO
module burst_stats_accum #(
  parameter int DWID  = burst_stats_pkg::DWID,
  parameter int SWID  = burst_stats_pkg::SWID,
  parameter int CWID  = burst_stats_pkg::CWID,
  parameter int DEPTH = 4
) (
  input  logic            sys_clk,
  input  logic            rst_n,
  input  logic            vldin,
  input  logic [DWID-1:0] din,
  input  logic            lastin,
  input  logic            softreset,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SWID-1:0] out_sum,
  output logic [CWID-1:0] out_count,
  output logic [DWID-1:0] out_min,
  output logic [DWID-1:0] out_max,
  output logic [1:0]      out_flags,
  output logic            busy,
  output logic [15:0]     drop_count
);
  import burst_stats_pkg::*;
  localparam int RW = SWID + CWID + 2*DWID + 2;
  state_t          r_state, w_next;
  logic [SWID-1:0] r_sum, w_sum_n, w_rec_sum;
  logic [CWID-1:0] r_count, w_count_n, w_rec_count;
  logic [DWID-1:0] r_min, r_max, w_min_n, w_max_n, w_rec_min, w_rec_max;
  logic [1:0]      r_flags, w_flags_n, w_rec_flags;
  logic [15:0]     r_drop;
  logic [SWID:0]   w_add;
  logic            w_first, w_cnt_max, w_push, w_pop, w_full, w_empty;
  logic [RW-1:0]   w_rdata;
  assign w_first   = r_state == IDLE;
  assign w_add     = {1'b0, r_sum} + (SWID+1)'(din);
  assign w_cnt_max = &r_count;
  assign w_sum_n   = w_add[SWID] ? '1 : w_add[SWID-1:0];
  assign w_count_n = w_cnt_max ? r_count : r_count + 1'b1;
  assign w_min_n   = din < r_min ? din : r_min;
  assign w_max_n   = din > r_max ? din : r_max;
  always_comb begin
    w_flags_n = r_flags;
    w_flags_n[FLAG_SAT] = r_flags[FLAG_SAT] | w_add[SWID];
    w_flags_n[FLAG_CNT] = r_flags[FLAG_CNT] | w_cnt_max;
  end
  // in IDLE the beat starts a fresh burst, otherwise it folds into the running stats
  assign w_rec_sum   = w_first ? SWID'(din) : w_sum_n;
  assign w_rec_count = w_first ? CWID'(1)   : w_count_n;
  assign w_rec_min   = w_first ? din        : w_min_n;
  assign w_rec_max   = w_first ? din        : w_max_n;
  assign w_rec_flags = w_first ? 2'b00      : w_flags_n;
  always_comb begin
    w_next = r_state;
    if (softreset) w_next = IDLE;
    else if (vldin) w_next = lastin ? IDLE : ACCUM;
  end
  always_ff @(posedge sys_clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge sys_clk or negedge rst_n)
    if (!rst_n) begin
      r_sum   <= '0;
      r_count <= '0;
      r_min   <= '0;
      r_max   <= '0;
      r_flags <= '0;
    end else if (softreset) begin
      r_sum   <= '0;
      r_count <= '0;
      r_min   <= '0;
      r_max   <= '0;
      r_flags <= '0;
    end else if (vldin) begin
      r_sum   <= w_rec_sum;
      r_count <= w_rec_count;
      r_min   <= w_rec_min;
      r_max   <= w_rec_max;
      r_flags <= w_rec_flags;
    end
  assign w_push = vldin & lastin & ~softreset;
  assign w_pop  = out_valid & out_ready;
  always_ff @(posedge sys_clk or negedge rst_n)
    if (!rst_n) r_drop <= '0;
    else if (softreset) r_drop <= '0;
    else if (w_push && w_full && !w_pop && !(&r_drop)) r_drop <= r_drop + 16'd1;
  burst_stats_fifo #(.W(RW), .DEPTH(DEPTH)) u_fifo (
    .sys_clk  (sys_clk),
    .rst_n    (rst_n),
    .softreset(softreset),
    .push     (w_push),
    .wdata    ({w_rec_sum, w_rec_count, w_rec_min, w_rec_max, w_rec_flags}),
    .pop      (w_pop),
    .rdata    (w_rdata),
    .full     (w_full),
    .empty    (w_empty)
  );
  assign out_valid = ~w_empty;
  assign {out_sum, out_count, out_min, out_max, out_flags} = w_rdata;
  assign busy       = r_state == ACCUM;
  assign drop_count = r_drop;
endmodule

// File: tb/tb_burst_stats_accum.sv
// tb_burst_stats_accum: directed scoreboard bench; a second instance with SWID=24 covers sum saturation
module tb_burst_stats_accum;
  typedef logic [89:0] rec_t;
  logic        clk = 0, rst_n = 0, vldin = 0, lastin = 0, softreset = 0, out_ready = 1, ready2 = 1;
  logic [19:0] din = 0;
  logic        out_valid, busy;
  logic [31:0] out_sum;
  logic [15:0] out_count, drop_count;
  logic [19:0] out_min, out_max;
  logic [1:0]  out_flags;
  logic        v2, busy2;
  logic [23:0] sum2;
  logic [15:0] cnt2, drop2;
  logic [19:0] min2, max2;
  logic [1:0]  flags2;
  int          checks = 0, errors = 0;
  rec_t        q[$];
  rec_t        exp_r, obs_r;

  always #5 clk = ~clk;

  burst_stats_accum dut (
    .sys_clk(clk), .rst_n(rst_n), .vldin(vldin), .din(din), .lastin(lastin), .softreset(softreset),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_count(out_count),
    .out_min(out_min), .out_max(out_max), .out_flags(out_flags), .busy(busy), .drop_count(drop_count)
  );

  burst_stats_accum #(.SWID(24)) dut2 (
    .sys_clk(clk), .rst_n(rst_n), .vldin(vldin), .din(din), .lastin(lastin), .softreset(softreset),
    .out_valid(v2), .out_ready(ready2), .out_sum(sum2), .out_count(cnt2),
    .out_min(min2), .out_max(max2), .out_flags(flags2), .busy(busy2), .drop_count(drop2)
  );

  function automatic rec_t mk(input logic [31:0] s, input logic [15:0] c,
                              input logic [19:0] mn, input logic [19:0] mx, input logic [1:0] f);
    return {s, c, mn, mx, f};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sync;
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [19:0] d, input logic l);
    vldin = 1; din = d; lastin = l;
    sync();
    vldin = 0; lastin = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) sync();
  endtask

  // scoreboard: every accepted record is compared against the oldest expectation
  always @(negedge clk)
    if (rst_n && out_valid && out_ready) begin
      obs_r = {out_sum, out_count, out_min, out_max, out_flags};
      checks++;
      if (q.size() == 0) begin
        errors++;
        $error("FAIL unexpected_record: observed %0h expected none", obs_r);
      end else begin
        exp_r = q.pop_front();
        assert (obs_r === exp_r) else begin
          errors++;
          $error("FAIL record: observed %0h expected %0h", obs_r, exp_r);
        end
      end
    end

  initial begin
    idle(2);
    @(negedge clk);
    chk("reset_valid", out_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_drop", drop_count, 0);
    chk("reset_rec", {out_sum, out_count, out_min, out_max, out_flags}, 0);
    sync();
    rst_n = 1;
    idle(2);

    q.push_back(mk(16, 4, 1, 7, 0));
    beat(3, 0);
    @(negedge clk);
    chk("busy_in_burst", busy, 1);
    sync();
    beat(5, 0);
    beat(1, 0);
    beat(7, 1);
    @(negedge clk);
    chk("latency_valid", out_valid, 1);
    chk("busy_after_last", busy, 0);
    @(negedge clk);
    chk("valid_one_cycle", out_valid, 0);
    sync();

    q.push_back(mk(9, 1, 9, 9, 0));
    vldin = 1; din = 9; lastin = 1;
    @(negedge clk);
    chk("single_busy_pre", busy, 0);
    sync();
    vldin = 0; lastin = 0;
    @(negedge clk);
    chk("single_busy", busy, 0);
    chk("single_valid", out_valid, 1);
    sync();
    idle(2);

    q.push_back(mk(32'h010FFFEF, 17, 20'hFFFFF, 20'hFFFFF, 0));
    for (int i = 0; i < 17; i++) beat(20'hFFFFF, i == 16);
    @(negedge clk);
    chk("sat_valid", v2, 1);
    chk("sat_sum", sum2, 24'hFFFFFF);
    chk("sat_flags", flags2, 2'b01);
    chk("sat_count", cnt2, 17);
    sync();
    idle(2);

    out_ready = 0;
    for (int k = 1; k <= 5; k++) begin
      if (k <= 4) q.push_back(mk(10 + 2*k, 2, 20'(k), 20'(10 + k), 0));
      beat(20'(k), 0);
      beat(20'(10 + k), 1);
    end
    @(negedge clk);
    chk("full_valid", out_valid, 1);
    chk("full_drop", drop_count, 1);
    chk("full_head_sum", out_sum, 12);
    sync();
    idle(2);
    @(negedge clk);
    chk("hold_head_sum", out_sum, 12);
    sync();
    out_ready = 1;
    idle(6);
    chk("drain_empty_q", q.size(), 0);
    chk("drain_valid", out_valid, 0);

    out_ready = 0;
    for (int k = 1; k <= 4; k++) begin
      q.push_back(mk(50 + 2*k, 2, 20'(20 + k), 20'(30 + k), 0));
      beat(20'(20 + k), 0);
      beat(20'(30 + k), 1);
    end
    q.push_back(mk(90, 2, 40, 50, 0));
    beat(40, 0);
    out_ready = 1;
    beat(50, 1);
    @(negedge clk);
    chk("pushpop_drop", drop_count, 1);
    chk("pushpop_valid", out_valid, 1);
    sync();
    idle(7);
    chk("pushpop_empty_q", q.size(), 0);
    chk("pushpop_drained", out_valid, 0);

    out_ready = 0;
    beat(77, 1);
    beat(4, 0);
    beat(4, 0);
    vldin = 1; din = 6; lastin = 1; softreset = 1;
    sync();
    vldin = 0; lastin = 0; softreset = 0;
    @(negedge clk);
    chk("srst_valid", out_valid, 0);
    chk("srst_busy", busy, 0);
    chk("srst_drop", drop_count, 0);
    sync();
    out_ready = 1;
    q.push_back(mk(4, 2, 2, 2, 0));
    beat(2, 0);
    beat(2, 1);
    idle(3);
    chk("srst_empty_q", q.size(), 0);
    chk("srst_drained", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
